// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, constants and helpers for the writeback port arbiter.
// Counter width applies only to builds with WB_ARB_STATS_EN.
package wb_arb_pkg;

  localparam int NREQ_DEF   = 3;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 32;

  localparam logic [ADDR_W_DEF-1:0] ZERO_REG = '0;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W_DEF = ptr_width(NREQ_DEF);

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester-side valid/ready bus plus the registered register-file write port.
// The arbiter uses the slave modport; requesters and the register file see master.
interface wb_port_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;

  logic                   rf_wen;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
// Produces a one-hot grant, its binary index and a found flag.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  always_comb begin
    logic [PTR_W:0] pos;
    // NOTE: every output gets a default before the loop so no path infers a latch.
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NREQ)) pos = pos - (PTR_W+1)'(NREQ);
      if (!found && valid[pos[PTR_W-1:0]]) begin
        onehot[pos[PTR_W-1:0]] = 1'b1;
        idx                    = pos[PTR_W-1:0];
        found                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback units.
// Define WB_ARB_STATS_EN to add per-requester accepted-write counters (grant_cnt).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  wb_port_arbiter_if.slave      bus,
  output logic                  stall
`ifdef WB_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int PTR_W = ptr_width(NREQ);

  logic [PTR_W-1:0]  rr_ptr;
  logic [NREQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_found;
  logic              grant_en;
  logic              handshake;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .valid  (bus.req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // The picker only grants valid requesters, so a grant is always a handshake.
  assign grant_en      = ~rst & ~flush;
  assign handshake     = grant_en & pick_found;
  assign bus.req_ready = grant_en ? pick_onehot : '0;
  assign stall         = ~rst & (|(bus.req_valid & ~bus.req_ready));

  assign sel_addr = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_data = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      // Writes to x0 are accepted and rotate the pointer but never reach the file.
      wen_q <= handshake && (sel_addr != ADDR_W'(ZERO_REG));
      if (handshake) begin
        rr_ptr  <= (pick_idx == PTR_W'(NREQ-1)) ? '0 : pick_idx + PTR_W'(1);
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.rf_wen   = wen_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;

`ifdef WB_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  // NOTE: these counters are discrete flops, not a RAM, so clearing them on reset is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (handshake) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (NREQ=3); counter checks
// run only when built with WB_ARB_STATS_EN.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic stall;
`ifdef WB_ARB_STATS_EN
  logic [NREQ*CNT_W-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  wb_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wb_port_arbiter #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .stall     (stall)
`ifdef WB_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [2:0] exp_rdy;

    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // Reset state: grant and stall are gated off even with everyone valid.
    bus.req_valid = 3'b111;
    #2;
    check("rst_ready", bus.req_ready, 3'b000);
    check("rst_stall", stall, 1'b0);
    check("rst_wen", bus.rf_wen, 1'b0);
    check("rst_waddr", bus.rf_waddr, 5'd0);
    check("rst_wdata", bus.rf_wdata, 32'h0);
    tick();
    rst           = 1'b0;
    bus.req_valid = '0;

    // Single requester 1.
    set_req(1, 5'd5, 32'hDEADBEEF);
    bus.req_valid = 3'b010;
    #1;
    check("single_ready", bus.req_ready, 3'b010);
    check("single_stall", stall, 1'b0);
    tick();
    check("single_wen", bus.rf_wen, 1'b1);
    check("single_waddr", bus.rf_waddr, 5'd5);
    check("single_wdata", bus.rf_wdata, 32'hDEADBEEF);
    bus.req_valid = '0;
    tick();
    check("idle_wen", bus.rf_wen, 1'b0);
    check("idle_waddr_hold", bus.rf_waddr, 5'd5);
    check("idle_wdata_hold", bus.rf_wdata, 32'hDEADBEEF);

    // x0 write from requester 2 (pointer is 2 here, wraps to 0 afterwards).
    set_req(2, 5'd0, 32'h00001234);
    bus.req_valid = 3'b100;
    #1;
    check("x0_ready", bus.req_ready, 3'b100);
    tick();
    check("x0_wen", bus.rf_wen, 1'b0);
    bus.req_valid = '0;

    // All valid for six cycles: grants 0,1,2,0,1,2 starting from pointer 0.
    set_req(0, 5'd1, 32'h000000A0);
    set_req(1, 5'd2, 32'h000000A1);
    set_req(2, 5'd3, 32'h000000A2);
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_rdy = 3'b001 << (c % 3);
      check($sformatf("rr_ready_%0d", c), bus.req_ready, exp_rdy);
      check($sformatf("rr_stall_%0d", c), stall, 1'b1);
      tick();
      check($sformatf("rr_wen_%0d", c), bus.rf_wen, 1'b1);
      check($sformatf("rr_waddr_%0d", c), bus.rf_waddr, 64'(c % 3 + 1));
      check($sformatf("rr_wdata_%0d", c), bus.rf_wdata, 64'(32'hA0 + c % 3));
    end
    bus.req_valid = '0;

    // Same address from two requesters: round-robin order, later grant wins.
    set_req(0, 5'd7, 32'h00000070);
    set_req(1, 5'd7, 32'h00000071);
    bus.req_valid = 3'b011;
    #1;
    check("same_ready0", bus.req_ready, 3'b001);
    check("same_stall0", stall, 1'b1);
    tick();
    check("same_wdata0", bus.rf_wdata, 32'h70);
    bus.req_valid = 3'b010;
    #1;
    check("same_ready1", bus.req_ready, 3'b010);
    tick();
    check("same_waddr1", bus.rf_waddr, 5'd7);
    check("same_wdata1", bus.rf_wdata, 32'h71);
    bus.req_valid = '0;

    // Move the pointer to 1, then flush with requesters 0 and 1 valid.
    set_req(0, 5'd9, 32'h00000090);
    set_req(1, 5'd10, 32'h00000091);
    bus.req_valid = 3'b001;
    #1;
    check("preflush_ready", bus.req_ready, 3'b001);
    tick();
    check("preflush_wen", bus.rf_wen, 1'b1);
    bus.req_valid = 3'b011;
    flush         = 1'b1;
    #1;
    check("flush_ready", bus.req_ready, 3'b000);
    check("flush_stall", stall, 1'b1);
    tick();
    check("flush_wen", bus.rf_wen, 1'b0);
    flush = 1'b0;
    #1;
    check("postflush_ready", bus.req_ready, 3'b010);
    tick();
    check("postflush_wen", bus.rf_wen, 1'b1);
    check("postflush_waddr", bus.rf_waddr, 5'd10);
    bus.req_valid = '0;

    // Asynchronous reset mid-cycle with a write on the port and pointer at 2.
    #2;
    rst = 1'b1;
    #1;
    check("arst_wen", bus.rf_wen, 1'b0);
    check("arst_waddr", bus.rf_waddr, 5'd0);
    check("arst_wdata", bus.rf_wdata, 32'h0);
    set_req(0, 5'd4, 32'h00000040);
    bus.req_valid = 3'b111;
    #1;
    check("arst_ready", bus.req_ready, 3'b000);
    tick();
    rst = 1'b0;
    #1;
    check("release_ready", bus.req_ready, 3'b001);
    tick();
    check("release_wen", bus.rf_wen, 1'b1);
    check("release_waddr", bus.rf_waddr, 5'd4);
    check("release_wdata", bus.rf_wdata, 32'h40);
    bus.req_valid = '0;

`ifdef WB_ARB_STATS_EN
    // Counters: fresh reset, four grants to req0, one to req2, then a flush.
    #2;
    rst = 1'b1;
    #2;
    check("cnt_rst", grant_cnt, 64'h0);
    tick();
    rst           = 1'b0;
    bus.req_valid = 3'b001;
    for (int c = 0; c < 4; c++) tick();
    bus.req_valid = 3'b100;
    tick();
    bus.req_valid = '0;
    check("cnt_req0", grant_cnt[0*CNT_W +: CNT_W], 4);
    check("cnt_req1", grant_cnt[1*CNT_W +: CNT_W], 0);
    check("cnt_req2", grant_cnt[2*CNT_W +: CNT_W], 1);
    bus.req_valid = 3'b111;
    flush         = 1'b1;
    tick();
    flush         = 1'b0;
    bus.req_valid = '0;
    check("cnt_flush_req0", grant_cnt[0*CNT_W +: CNT_W], 4);
    check("cnt_flush_req2", grant_cnt[2*CNT_W +: CNT_W], 1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
